// File: rtl/bram_word_ctrl_pkg.sv
// Shared types, constants and helpers for the 32-bit word controller that
// fronts one 256x16 iCE40 block RAM.
package bram_word_ctrl_pkg;

    localparam int          HALF_W    = 16;
    localparam int          BRAM_AW   = 8;
    localparam logic [15:0] MASK_NONE = 16'hFFFF;

    // Controller state encoding (plain constants so older tools and
    // checkers can decode the debug state bus directly).
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WR_LO  = 3'd1;
    localparam state_t ST_WR_HI  = 3'd2;
    localparam state_t ST_RD_LO  = 3'd3;
    localparam state_t ST_RD_HI  = 3'd4;
    localparam state_t ST_RD_CAP = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    // Two byte enables of one 16-bit half -> BRAM active-low bit mask.
    function automatic logic [HALF_W-1:0] be2mask(input logic [1:0] be);
        return ~{{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/bram_word_ctrl_if.sv
// Word request/response port between the sail-core data path (master)
// and the block RAM controller (slave).
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both 1; the requester holds req_valid and the request
// fields stable until then. rsp_valid is a single-cycle pulse with no
// back-pressure; rsp_rdata holds until the next read completes.
interface bram_word_ctrl_if #(
    parameter int WORD_AW = 7
) ();
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [WORD_AW-1:0] req_addr;
    logic [31:0]        req_wdata;
    logic [3:0]         req_be;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bram_word_ctrl.sv
// bram_word_ctrl: splits each 32-bit word access into two 16-bit accesses
// of an SB_RAM40_4K (mode 0), low half at 2*idx, high half at 2*idx+1.
// All BRAM-facing outputs are registered; the 1-cycle read latency is
// hidden behind the RD_CAP state.
// Optional build macro: BRAM_WORD_CTRL_SKIP_EMPTY_EN skips write halves
// whose two byte enables are both clear.
module bram_word_ctrl
    import bram_word_ctrl_pkg::*;
#(
    parameter int WORD_AW = 7,
    parameter bit WR_ACK  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    bram_word_ctrl_if.slave     bus,
    output logic [BRAM_AW-1:0]  ram_waddr,
    output logic [HALF_W-1:0]   ram_wdata,
    output logic [HALF_W-1:0]   ram_mask,
    output logic                ram_we,
    output logic [BRAM_AW-1:0]  ram_raddr,
    output logic                ram_re,
    input  logic [HALF_W-1:0]   ram_rdata,
    output state_t              dbg_state
);

    state_t             state;
    state_t             nxt_state;
    logic               we_q;
    logic [WORD_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [HALF_W-1:0]  lo_q;

    // Request fields as seen this cycle: live inputs while idle, latched copy otherwise.
    logic               cur_we;
    logic [WORD_AW-1:0] cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_be;

    logic               nxt_we;
    logic               nxt_re;
    logic               nxt_hi;

    assign bus.req_ready = (state == ST_IDLE);
    assign dbg_state     = state;

    // Next-state decode and the request view that feeds the registered BRAM outputs.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
        end

        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
`ifdef BRAM_WORD_CTRL_SKIP_EMPTY_EN
                        if (bus.req_be[1:0] != 2'b00)
                            nxt_state = ST_WR_LO;
                        else if (bus.req_be[3:2] != 2'b00)
                            nxt_state = ST_WR_HI;
                        else
                            nxt_state = ST_DONE;
`else
                        nxt_state = ST_WR_LO;
`endif
                    end else begin
                        nxt_state = ST_RD_LO;
                    end
                end
            end
            ST_WR_LO: begin
`ifdef BRAM_WORD_CTRL_SKIP_EMPTY_EN
                nxt_state = (be_q[3:2] != 2'b00) ? ST_WR_HI : ST_DONE;
`else
                nxt_state = ST_WR_HI;
`endif
            end
            ST_WR_HI:  nxt_state = ST_DONE;
            ST_RD_LO:  nxt_state = ST_RD_HI;
            ST_RD_HI:  nxt_state = ST_RD_CAP;
            ST_RD_CAP: nxt_state = ST_DONE;
            ST_DONE:   nxt_state = ST_IDLE;
            default:   nxt_state = ST_IDLE;
        endcase

        nxt_we = (nxt_state == ST_WR_LO) || (nxt_state == ST_WR_HI);
        nxt_re = (nxt_state == ST_RD_LO) || (nxt_state == ST_RD_HI);
        nxt_hi = (nxt_state == ST_WR_HI) || (nxt_state == ST_RD_HI);
    end

    // State register and registered BRAM strobes/addresses/data for the coming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ram_we        <= 1'b0;
            ram_waddr     <= '0;
            ram_wdata     <= '0;
            ram_mask      <= MASK_NONE;
            ram_re        <= 1'b0;
            ram_raddr     <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            state     <= nxt_state;
            ram_we    <= nxt_we;
            ram_waddr <= nxt_we ? {cur_addr, nxt_hi} : '0;
            ram_wdata <= !nxt_we ? '0 : (nxt_hi ? cur_wdata[31:16] : cur_wdata[15:0]);
            ram_mask  <= !nxt_we ? MASK_NONE
                                 : (nxt_hi ? be2mask(cur_be[3:2]) : be2mask(cur_be[1:0]));
            ram_re    <= nxt_re;
            ram_raddr <= nxt_re ? {cur_addr, nxt_hi} : '0;
            // Silent writes still spend the DONE cycle, just without the pulse.
            bus.rsp_valid <= (nxt_state == ST_DONE) && (!cur_we || WR_ACK);
        end
    end

    // Latch the request on acceptance so the requester's fields are free afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state == ST_IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Assemble read data: low half arrives during RD_HI, high half during RD_CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q          <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            if (state == ST_RD_HI)
                lo_q <= ram_rdata;
            if (state == ST_RD_CAP)
                bus.rsp_rdata <= {ram_rdata, lo_q};
        end
    end

endmodule

// File: tb/tb_bram_word_ctrl.sv
// Testbench for bram_word_ctrl: behavioural SB_RAM40_4K model, directed
// word accesses, and a scoreboard of expected BRAM strobes and responses
// (each tagged with the cycle it must appear in).
module tb_bram_word_ctrl;
    import bram_word_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_mask;
    logic        ram_we;
    logic [7:0]  ram_raddr;
    logic        ram_re;
    logic [15:0] ram_rdata;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] last_rd = '0;

    // {cycle, waddr, wdata, mask}
    logic [55:0] exp_wr_q[$];
    // {cycle, raddr}
    logic [23:0] exp_rd_q[$];
    // {cycle, rdata}
    logic [47:0] exp_q[$];

    logic [15:0] mem [0:255];

    bram_word_ctrl_if #(.WORD_AW(7)) bus_if ();

    bram_word_ctrl #(.WORD_AW(7), .WR_ACK(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_mask  (ram_mask),
        .ram_we    (ram_we),
        .ram_raddr (ram_raddr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Block RAM model: masked write, registered read
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= (mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or responds
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", {8'd0, cyc[15:0], ram_waddr, ram_wdata, ram_mask}, 64'd0);
                else check("bram_write", {8'd0, cyc[15:0], ram_waddr, ram_wdata, ram_mask}, {8'd0, exp_wr_q.pop_front()});
            end else begin
                check("idle_mask", {48'd0, ram_mask}, {48'd0, MASK_NONE});
            end
            if (ram_re) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", {40'd0, cyc[15:0], ram_raddr}, 64'd0);
                else check("bram_read", {40'd0, cyc[15:0], ram_raddr}, {40'd0, exp_rd_q.pop_front()});
            end
            if (bus_if.rsp_valid) begin
                if (exp_q.size() == 0) check("unexpected_rsp", {16'd0, cyc[15:0], bus_if.rsp_rdata}, 64'd0);
                else check("response", {16'd0, cyc[15:0], bus_if.rsp_rdata}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver: present a request and return the acceptance cycle
    task automatic issue(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int t);
        int n;
        @(negedge clk);
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_be    = be;
        bus_if.req_valid = 1'b1;
        n = 0;
        while (!bus_if.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout: req_ready never rose for addr %0d", addr);
        end
        t = cyc;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                            input logic [15:0] lo_mask, input logic [15:0] hi_mask,
                            input bit lo_on, input bit hi_on, input bit hold);
        int t;
        logic [15:0] c;
        issue(1'b1, addr, wdata, be, t);
        c = 16'(t + 1);
        if (lo_on) begin
            exp_wr_q.push_back({c, addr, 1'b0, wdata[15:0], lo_mask});
            c++;
        end
        if (hi_on) begin
            exp_wr_q.push_back({c, addr, 1'b1, wdata[31:16], hi_mask});
            c++;
        end
        exp_q.push_back({c, last_rd});
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("ready_busy", {63'd0, bus_if.req_ready}, 64'd0);
            end
            bus_if.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus_if.req_valid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [31:0] exp_data, input bit expect_rsp,
                           output int t);
        issue(1'b0, addr, 32'd0, 4'd0, t);
        exp_rd_q.push_back({16'(t + 1), addr, 1'b0});
        exp_rd_q.push_back({16'(t + 2), addr, 1'b1});
        if (expect_rsp) begin
            exp_q.push_back({16'(t + 4), exp_data});
            last_rd = exp_data;
        end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
    endtask

    // Stimulus
    initial begin
        int t;
        int n;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.req_be    = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready",  {63'd0, bus_if.req_ready}, 64'd1);
        check("rst_valid",  {63'd0, bus_if.rsp_valid}, 64'd0);
        check("rst_rdata",  {32'd0, bus_if.rsp_rdata}, 64'd0);
        check("rst_we_re",  {62'd0, ram_we, ram_re}, 64'd0);
        check("rst_mask",   {48'd0, ram_mask}, 64'hFFFF);
        check("rst_addr",   {32'd0, ram_waddr, ram_raddr, ram_wdata}, 64'd0);
        check("rst_state",  {61'd0, dbg_state}, {61'd0, ST_IDLE});
        rst = 1'b0;

        // Full word write then read back
        do_write(7'd5, 32'hDEADBEEF, 4'hF, 16'h0000, 16'h0000, 1, 1, 0);
        do_read(7'd5, 32'hDEADBEEF, 1, t);
        // Single byte in the high half
`ifdef BRAM_WORD_CTRL_SKIP_EMPTY_EN
        do_write(7'd5, 32'h11223344, 4'b0100, 16'hFFFF, 16'hFF00, 0, 1, 0);
`else
        do_write(7'd5, 32'h11223344, 4'b0100, 16'hFFFF, 16'hFF00, 1, 1, 0);
`endif
        do_read(7'd5, 32'hDE22BEEF, 1, t);
        // Top word, requester keeps req_valid high while busy
        do_write(7'd127, 32'hCAFEF00D, 4'hF, 16'h0000, 16'h0000, 1, 1, 1);
        do_read(7'd127, 32'hCAFEF00D, 1, t);
        // Mixed bytes across halves
        do_write(7'd0, 32'hA1B2C3D4, 4'b1001, 16'hFF00, 16'h00FF, 1, 1, 0);
        do_read(7'd0, 32'hA10000D4, 1, t);
        // Empty byte enables: nothing written, still acknowledged
`ifdef BRAM_WORD_CTRL_SKIP_EMPTY_EN
        do_write(7'd127, 32'h00000000, 4'b0000, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        do_write(7'd3, 32'h55667788, 4'b1100, 16'hFFFF, 16'h0000, 0, 1, 0);
`else
        do_write(7'd127, 32'h00000000, 4'b0000, 16'hFFFF, 16'hFFFF, 1, 1, 0);
        do_write(7'd3, 32'h55667788, 4'b1100, 16'hFFFF, 16'h0000, 1, 1, 0);
`endif
        do_read(7'd127, 32'hCAFEF00D, 1, t);
        do_read(7'd3, 32'h55660000, 1, t);

        // Reset while the controller is in RD_HI
        n = 0;
        while (!bus_if.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        do_read(7'd5, 32'h0, 0, t);
        while (cyc < t + 2) @(negedge clk);
        #2;
        check("pre_rst_state", {61'd0, dbg_state}, {61'd0, ST_RD_HI});
        rst = 1'b1;
        #1;
        check("mid_rst_re",    {63'd0, ram_re}, 64'd0);
        check("mid_rst_ready", {63'd0, bus_if.req_ready}, 64'd1);
        check("mid_rst_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
        check("mid_rst_rdata", {32'd0, bus_if.rsp_rdata}, 64'd0);
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Recovery after reset
        do_read(7'd5, 32'hDE22BEEF, 1, t);

        n = 0;
        while ((exp_q.size() + exp_wr_q.size() + exp_rd_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("left_rsp",   64'(exp_q.size()), 64'd0);
        check("left_write", 64'(exp_wr_q.size()), 64'd0);
        check("left_read",  64'(exp_rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
